rob_commit: RTL and testbench
=============================

# rob_commit

In-order reorder buffer that sits directly upstream of the register file's commit port. It allocates a 3-bit rename tag (1..7, tag 0 meaning "no dependency") to each issued instruction. It captures results from the common data bus out of order and retires entries strictly in program order, driving commit, reg_num, data_in and num_in of the register file. Operand-query ports let issue logic read results that have been written back but not yet committed.

## Interface
Parameters:
- DEPTH, 7: number of entries; tags 1..DEPTH; must be ≤ 7 so a tag fits in 3 bits with 0 reserved.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- issue_valid  in  1  allocate an entry this edge (honoured only when issue_ready=1).
- issue_has_rd  in  1  instruction writes a destination register.
- issue_rd  in  5  destination register index.
- issue_ready  out  1  combinational; 1 when count < DEPTH.
- issue_tag  out  3  combinational; tag the next allocation receives (tail tag). Feeds the register file's dependency_num.
- wb_valid  in  1  CDB result valid.
- wb_tag  in  3  tag of the CDB result.
- wb_data  in  32  CDB result value.
- q1_tag, q2_tag  in  3 each  operand tags to look up.
- q1_ready, q2_ready  out  1 each  combinational; result for that tag is available.
- q1_value, q2_value  out  32 each  combinational; the available result, 0 when not ready.
- commit  out  1  registered; one-cycle pulse, a register write to the register file.
- commit_reg  out  5  registered; destination register (reg_num).
- commit_data  out  32  registered; value (data_in).
- commit_tag  out  3  registered; retiring tag (num_in).
- retire  out  1  registered; one-cycle pulse for every retired entry, including no-rd entries.
- count  out  3  registered; number of occupied entries.

## Operation
- Per-entry state: busy, ready, has_rd, rd[4:0], value[31:0]. Entry for tag t is slot t-1.
- head, tail: 3-bit tag pointers, both reset to 1. Advance rule: t → t+1, and DEPTH → 1. They never take value 0.
- Issue (issue_valid && issue_ready) at an edge:
  - sets slot[tail] to busy=1, ready=0, has_rd, rd;
  - advances tail and increments count.
- Writeback (wb_valid) at an edge:
  - if wb_tag≠0 and slot[wb_tag] is busy, sets ready=1 and value=wb_data;
  - otherwise ignored. A repeated writeback to the same busy tag overwrites value.
- Retire at an edge when slot[head] is busy and ready:
  - clears busy and advances head;
  - decrements count;
  - pulses retire=1 with commit_tag=head;
  - sets commit=1 only if has_rd && rd≠0, so x0 and store/branch entries never write the register file;
  - commit_reg and commit_data load the entry's rd and value in every retire.
- At most one retire per cycle. When no retire occurs: commit=0 and retire=0, while commit_reg, commit_data and commit_tag hold.
- Issue and retire in the same edge: count unchanged. issue_ready is computed from registered count only, with no same-cycle retire bypass; a full ROB therefore stalls issue one cycle even while retiring.
- Query, for each port:
  - tag 0 → ready=0;
  - wb_valid && wb_tag==q_tag && slot busy → ready=1, value=wb_data (CDB bypass);
  - else slot busy && ready → ready=1, value=slot value;
  - else ready=0, value=0.
- Reset (rst=0 at an edge) overrides all other activity and drops in-flight entries:
  - clears all busy and ready bits;
  - sets head=tail=1 and count=0;
  - sets commit, retire, commit_reg, commit_data and commit_tag to 0.

## Timing
- Allocation: issue_tag valid in the cycle of issue; entry is occupied from the following edge.
- Writeback to commit, minimum latency: writeback captured at edge M; retire evaluated at edge M+1; commit/retire high for the cycle after edge M+1 (one clock after writeback).
- Issue to commit, minimum: the head entry is issued at edge N, written back at edge N+1, and committed with outputs high after edge N+2.
- A writeback to the head at edge M does not retire at edge M; the ready bit is read as registered.
- Back-to-back ready entries retire on consecutive cycles, one per cycle.
- Query outputs are purely combinational from current state plus the wb bus, with no added latency.

## Test plan
- Reset then idle: rst=0 for 2 cycles → issue_tag=1, issue_ready=1, count=0, commit=0, retire=0, commit_data=0.
- Single instruction: issue rd=5 (tag 1), wb tag1 data 0xDEADBEEF the next cycle → after the following edge, commit=1, commit_reg=5, commit_data=0xDEADBEEF, commit_tag=1 for exactly one cycle; count returns to 0.
- Out-of-order writeback: issue tags 1,2,3 (rd 1,2,3); wb order 3,2,1 → commits occur in order tags 1,2,3 on three consecutive cycles after tag 1's writeback, with matching values.
- Full and wrap:
  - issue 7 → issue_ready=0, count=7, and an issue_valid asserted while full is ignored;
  - retire one → next issue_tag=1 after wrap; tags proceed 1,2,… with no tag 0.
- x0/no-rd entry: issue rd=0, wb it → retire=1 while commit=0; a query to its tag returns ready until retire.
- Bypass and reset mid-flight:
  - q1_tag=2 with wb tag2 0x1234 in the same cycle → q1_ready=1, q1_value=0x1234;
  - then rst=0 with 3 entries busy → count=0, head=tail=1, and no commit afterwards.

Source files
------------

// File: rtl/rob_commit_if.sv
// Issue, CDB writeback, operand query and register-file commit signals of the reorder buffer.
// master drives issue/writeback/query; slave is the reorder buffer itself.
interface rob_commit_if;
  logic        issue_valid;
  logic        issue_has_rd;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [31:0] wb_data;
  logic [2:0]  q1_tag;
  logic [2:0]  q2_tag;
  logic        q1_ready;
  logic        q2_ready;
  logic [31:0] q1_value;
  logic [31:0] q2_value;
  logic        commit;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;
  logic [2:0]  commit_tag;
  logic        retire;
  logic [2:0]  count;

  modport master (
    output issue_valid, issue_has_rd, issue_rd, wb_valid, wb_tag, wb_data, q1_tag, q2_tag,
    input  issue_ready, issue_tag, q1_ready, q2_ready, q1_value, q2_value,
           commit, commit_reg, commit_data, commit_tag, retire, count
  );

  modport slave (
    input  issue_valid, issue_has_rd, issue_rd, wb_valid, wb_tag, wb_data, q1_tag, q2_tag,
    output issue_ready, issue_tag, q1_ready, q2_ready, q1_value, q2_value,
           commit, commit_reg, commit_data, commit_tag, retire, count
  );
endinterface

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates tags 1..DEPTH, captures CDB results out of order
// and retires one entry per cycle in program order into the register-file commit port.
module rob_commit #(
  parameter int unsigned DEPTH = 7
) (
  input logic         clk,
  input logic         rst,
  rob_commit_if.slave rob
);

  localparam logic [2:0] LAST = 3'(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [DEPTH-1:0] has_rd_q, has_rd_d;
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];
  logic [31:0]      value_q [DEPTH];
  logic [31:0]      value_d [DEPTH];
  logic [2:0]       head_q, head_d;
  logic [2:0]       tail_q, tail_d;
  logic [2:0]       count_q, count_d;
  logic             commit_q, commit_d;
  logic             retire_q, retire_d;
  logic [4:0]       commit_reg_q, commit_reg_d;
  logic [31:0]      commit_data_q, commit_data_d;
  logic [2:0]       commit_tag_q, commit_tag_d;

  logic        issue_ready;
  logic        issue_fire;
  logic        retire_fire;
  logic [2:0]  head_idx;
  logic [2:0]  tail_idx;
  logic [2:0]  wb_idx;
  logic [32:0] q1_res;
  logic [32:0] q2_res;

  function automatic logic tag_ok(input logic [2:0] t);
    return (t != 3'd0) && (t <= LAST);
  endfunction

  function automatic logic [2:0] adv(input logic [2:0] t);
    return (t == LAST) ? 3'd1 : t + 3'd1;
  endfunction

  // {ready, value}; a same-cycle CDB hit on a busy tag wins over the stored value
  function automatic logic [32:0] lookup(input logic [2:0] t, input logic wv,
                                         input logic [2:0] wt, input logic [31:0] wd);
    logic [2:0]  idx;
    logic [32:0] res;
    idx = t - 3'd1;
    res = '0;
    if (tag_ok(t) && busy_q[idx]) begin
      if (wv && (wt == t))    res = {1'b1, wd};
      else if (ready_q[idx])  res = {1'b1, value_q[idx]};
    end
    return res;
  endfunction

  assign issue_ready = (count_q < LAST);

  always_comb begin
    busy_d        = busy_q;
    ready_d       = ready_q;
    has_rd_d      = has_rd_q;
    rd_d          = rd_q;
    value_d       = value_q;
    head_d        = head_q;
    tail_d        = tail_q;
    commit_d      = 1'b0;
    retire_d      = 1'b0;
    commit_reg_d  = commit_reg_q;
    commit_data_d = commit_data_q;
    commit_tag_d  = commit_tag_q;
    head_idx      = head_q - 3'd1;
    tail_idx      = tail_q - 3'd1;
    wb_idx        = rob.wb_tag - 3'd1;
    issue_fire    = rob.issue_valid && issue_ready;
    retire_fire   = busy_q[head_idx] && ready_q[head_idx];

    if (rob.wb_valid && tag_ok(rob.wb_tag) && busy_q[wb_idx]) begin
      ready_d[wb_idx] = 1'b1;
      value_d[wb_idx] = rob.wb_data;
    end

    // Retire reads registered ready/value, so a writeback to the head lands first next cycle
    if (retire_fire) begin
      busy_d[head_idx]  = 1'b0;
      ready_d[head_idx] = 1'b0;
      head_d            = adv(head_q);
      retire_d          = 1'b1;
      commit_d          = has_rd_q[head_idx] && (rd_q[head_idx] != 5'd0);
      commit_reg_d      = rd_q[head_idx];
      commit_data_d     = value_q[head_idx];
      commit_tag_d      = head_q;
    end

    if (issue_fire) begin
      busy_d[tail_idx]   = 1'b1;
      ready_d[tail_idx]  = 1'b0;
      has_rd_d[tail_idx] = rob.issue_has_rd;
      rd_d[tail_idx]     = rob.issue_rd;
      tail_d             = adv(tail_q);
    end

    count_d = count_q + {2'b00, issue_fire} - {2'b00, retire_fire};

    q1_res = lookup(rob.q1_tag, rob.wb_valid, rob.wb_tag, rob.wb_data);
    q2_res = lookup(rob.q2_tag, rob.wb_valid, rob.wb_tag, rob.wb_data);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q        <= '0;
      ready_q       <= '0;
      head_q        <= 3'd1;
      tail_q        <= 3'd1;
      count_q       <= '0;
      commit_q      <= 1'b0;
      retire_q      <= 1'b0;
      commit_reg_q  <= '0;
      commit_data_q <= '0;
      commit_tag_q  <= '0;
    end else begin
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_q      <= commit_d;
      retire_q      <= retire_d;
      commit_reg_q  <= commit_reg_d;
      commit_data_q <= commit_data_d;
      commit_tag_q  <= commit_tag_d;
    end
  end

  // Payload is qualified by busy, so it needs no reset
  always_ff @(posedge clk) begin
    has_rd_q <= has_rd_d;
    rd_q     <= rd_d;
    value_q  <= value_d;
  end

  assign rob.issue_ready = issue_ready;
  assign rob.issue_tag   = tail_q;
  assign rob.q1_ready    = q1_res[32];
  assign rob.q1_value    = q1_res[31:0];
  assign rob.q2_ready    = q2_res[32];
  assign rob.q2_value    = q2_res[31:0];
  assign rob.commit      = commit_q;
  assign rob.commit_reg  = commit_reg_q;
  assign rob.commit_data = commit_data_q;
  assign rob.commit_tag  = commit_tag_q;
  assign rob.retire      = retire_q;
  assign rob.count       = count_q;

endmodule

// File: tb/tb_rob_commit.sv
// Randomized scoreboard bench for rob_commit: an in-order queue model predicts retirements,
// and a negedge monitor pops and compares them whenever the DUT pulses retire.
module tb_rob_commit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rob_commit_if ifc ();
  rob_commit #(.DEPTH(7)) dut (.clk(clk), .rst(rst), .rob(ifc));

  typedef struct {
    logic [2:0]  tag;
    logic        has_rd;
    logic [4:0]  rd;
    logic        rdy;
    logic [31:0] val;
  } ent_t;

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wr;
  } ret_t;

  ent_t rob_m[$];
  ret_t exp_q[$];
  ret_t mon_r;
  logic [2:0]  next_tag = 3'd1;
  logic        exp_retire = 1'b0;
  logic        exp_commit = 1'b0;
  logic [4:0]  last_reg = '0;
  logic [31:0] last_data = '0;
  logic [2:0]  last_tag = '0;
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int find(input logic [2:0] t);
    for (int i = 0; i < rob_m.size(); i++) if (rob_m[i].tag == t) return i;
    return -1;
  endfunction

  function automatic logic [32:0] model_query(input logic [2:0] t);
    int i;
    if (t == 3'd0) return '0;
    i = find(t);
    if (i < 0) return '0;
    if (ifc.wb_valid && ifc.wb_tag == t) return {1'b1, ifc.wb_data};
    if (rob_m[i].rdy) return {1'b1, rob_m[i].val};
    return '0;
  endfunction

  task automatic cycle(input logic rstn, input logic iv, input logic hr, input logic [4:0] rd,
                       input logic wv, input logic [2:0] wt, input logic [31:0] wd,
                       input logic [2:0] t1, input logic [2:0] t2);
    logic [32:0] e1, e2;
    logic can_issue;
    ent_t e;
    int i;
    @(negedge clk);
    rst = rstn;
    ifc.issue_valid = iv; ifc.issue_has_rd = hr; ifc.issue_rd = rd;
    ifc.wb_valid = wv; ifc.wb_tag = wt; ifc.wb_data = wd;
    ifc.q1_tag = t1; ifc.q2_tag = t2;
    #1;
    e1 = model_query(t1);
    e2 = model_query(t2);
    chk("issue_ready", 32'(ifc.issue_ready), 32'(rob_m.size() < 7));
    chk("issue_tag", 32'(ifc.issue_tag), 32'(next_tag));
    chk("q1_ready", 32'(ifc.q1_ready), 32'(e1[32]));
    chk("q1_value", ifc.q1_value, e1[31:0]);
    chk("q2_ready", 32'(ifc.q2_ready), 32'(e2[32]));
    chk("q2_value", ifc.q2_value, e2[31:0]);
    @(posedge clk);
    if (!rstn) begin
      rob_m.delete(); exp_q.delete();
      next_tag = 3'd1; exp_retire = 1'b0; exp_commit = 1'b0;
      last_reg = '0; last_data = '0; last_tag = '0;
    end else begin
      can_issue  = rob_m.size() < 7;
      exp_retire = rob_m.size() > 0 && rob_m[0].rdy;
      exp_commit = 1'b0;
      if (exp_retire) begin
        e = rob_m.pop_front();
        exp_commit = e.has_rd && e.rd != 5'd0;
        last_reg = e.rd; last_data = e.val; last_tag = e.tag;
        exp_q.push_back('{tag: e.tag, rd: e.rd, data: e.val, wr: exp_commit});
      end
      if (wv) begin
        i = find(wt);
        if (i >= 0) begin rob_m[i].rdy = 1'b1; rob_m[i].val = wd; end
      end
      if (iv && can_issue) begin
        rob_m.push_back('{tag: next_tag, has_rd: hr, rd: rd, rdy: 1'b0, val: '0});
        next_tag = (next_tag == 3'd7) ? 3'd1 : next_tag + 3'd1;
      end
    end
    #1;
    chk("count", 32'(ifc.count), 32'(rob_m.size()));
    chk("retire", 32'(ifc.retire), 32'(exp_retire));
    chk("commit", 32'(ifc.commit), 32'(exp_commit));
    if (!exp_retire) begin
      chk("hold_reg", 32'(ifc.commit_reg), 32'(last_reg));
      chk("hold_data", ifc.commit_data, last_data);
      chk("hold_tag", 32'(ifc.commit_tag), 32'(last_tag));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, '0, 3'd0, 3'd0);
  endtask

  always @(negedge clk) begin
    if (ifc.retire === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_retire: got tag %0d, expected no retire at %0t", ifc.commit_tag, $time);
      end else begin
        mon_r = exp_q.pop_front();
        chk("ret_tag", 32'(ifc.commit_tag), 32'(mon_r.tag));
        chk("ret_reg", 32'(ifc.commit_reg), 32'(mon_r.rd));
        chk("ret_data", ifc.commit_data, mon_r.data);
        chk("ret_commit", 32'(ifc.commit), 32'(mon_r.wr));
      end
    end
  end

  initial begin
    logic [2:0] wt;
    ifc.issue_valid = 1'b0; ifc.issue_has_rd = 1'b0; ifc.issue_rd = '0;
    ifc.wb_valid = 1'b0; ifc.wb_tag = '0; ifc.wb_data = '0;
    ifc.q1_tag = '0; ifc.q2_tag = '0;

    repeat (2) cycle(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, '0, 3'd0, 3'd0);
    chk("rst_issue_tag", 32'(ifc.issue_tag), 32'd1);
    chk("rst_commit_data", ifc.commit_data, 32'd0);

    // single instruction, minimum latency
    cycle(1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 3'd0, '0, 3'd1, 3'd0);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 3'd1, 32'hDEADBEEF, 3'd1, 3'd0);
    idle(1);
    chk("single_commit", 32'(ifc.commit), 32'd1);
    chk("single_data", ifc.commit_data, 32'hDEADBEEF);
    idle(1);

    // out-of-order writeback, in-order commit
    for (int i = 1; i <= 3; i++)
      cycle(1'b1, 1'b1, 1'b1, 5'(i), 1'b0, 3'd0, '0, 3'd0, 3'd0);
    for (int i = 3; i >= 1; i--)
      cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, rob_m[i-1].tag, 32'h100 + 32'(i), rob_m[0].tag, 3'd0);
    idle(4);

    // fill, one ignored issue, then wrap
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 1'b1, 1'b1, 5'(i + 8), 1'b0, 3'd0, '0, 3'd0, 3'd0);
    chk("full_count", 32'(ifc.count), 32'd7);
    chk("full_ready", 32'(ifc.issue_ready), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 5'd20, 1'b1, rob_m[0].tag, 32'hCAFE0001, 3'd0, 3'd0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 1'b1, 1'b1, 5'(i + 21), 1'b1, rob_m[0].tag, $urandom, rob_m[0].tag, 3'd0);

    // x0 destination and same-cycle bypass, then reset mid-flight
    idle(1);
    cycle(1'b1, 1'b1, 1'b1, 5'd0, 1'b1, rob_m[0].tag, 32'h55, 3'd0, 3'd0);
    for (int i = 0; i < 10 && rob_m.size() > 0; i++)
      cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, rob_m[0].tag, 32'h1234, rob_m[0].tag, rob_m[rob_m.size()-1].tag);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b1, 1'b1, 5'(i + 1), 1'b0, 3'd0, '0, 3'd0, 3'd0);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 3'd2, 32'h1234, 3'd2, 3'd1);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, '0, 3'd2, 3'd1);
    idle(3);

    // randomized traffic with rare resets
    for (int c = 0; c < 600; c++) begin
      if (rob_m.size() > 0 && $urandom_range(3, 0) != 0)
        wt = rob_m[$urandom_range(rob_m.size() - 1, 0)].tag;
      else
        wt = 3'($urandom_range(7, 0));
      cycle(($urandom_range(99, 0) != 0), ($urandom_range(9, 0) < 6), 1'($urandom),
            ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom), ($urandom_range(9, 0) < 6),
            wt, $urandom, 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
    end

    for (int i = 0; i < 40 && rob_m.size() > 0; i++)
      cycle(1'b1, 1'b0, 1'b0, 5'd0, 1'b1, rob_m[0].tag, $urandom, 3'd0, 3'd0);
    idle(2);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    chk("drain_count", 32'(ifc.count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
